crack_sched: RTL and testbench
==============================

Name: crack_sched

Overview:
- Top-level controller for the parallel ARC4 key search.
- Splits the key space into fixed-size chunks and dispatches them to NUM_CORES cracker cores using the en/rdy handshake.
- Round-robin arbitrates the single shared ciphertext (ct) memory read port among the cores.
- Collects the first found key, aborts all cores, and reports the result upward to the task-level wrapper.

Parameters:
- NUM_CORES, 2, number of cracker cores (2..8).
- KEY_BITS, 24, key space width; keys searched are 0 .. 2^KEY_BITS-1.
- CHUNK_SIZE, 4096, keys per dispatched chunk; power of two, at most 2^KEY_BITS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  start pulse; accepted only while rdy=1
- rdy  out  1  idle / result stable
- key_valid  out  1  a key was found in the last search
- key  out  KEY_BITS  found key
- core_en  out  NUM_CORES  one-hot, one-cycle chunk dispatch pulse
- core_base  out  KEY_BITS  first key of the chunk being dispatched; valid with core_en
- core_rdy  in  NUM_CORES  core idle (chunk finished or never started)
- core_found  in  NUM_CORES  one-cycle pulse, core found a key
- core_key  in  NUM_CORES*KEY_BITS  per-core found key; valid with core_found
- core_abort  out  1  one-cycle pulse forcing all cores idle
- core_ct_req  in  NUM_CORES  ct read request; held until granted
- core_ct_addr  in  NUM_CORES*8  per-core ct address
- core_ct_gnt  out  NUM_CORES  one-hot, combinational grant
- core_ct_rvalid  out  NUM_CORES  one-hot, one cycle after grant
- core_ct_rdata  out  8  broadcast read data
- ct_addr  out  8  to ct memory
- ct_rddata  in  8  from ct memory; synchronous read, 1-cycle latency

Behaviour:
- Reset values:
  - rdy=1, key_valid=0, key=0, core_en=0, core_base=0, core_abort=0.
  - core_ct_gnt=0, core_ct_rvalid=0, ct_addr=0.
  - Dispatch pointer=0, arbitration pointer=0, state IDLE.
  - Reset mid-search returns to IDLE in one cycle. No abort pulse is issued; cores are reset by the same rst.
- IDLE:
  - en=1 clears key_valid, sets next_key=0 (counter is KEY_BITS+1 wide), drops rdy next cycle, and enters RUN.
  - en while rdy=0 is ignored.
- RUN, dispatch:
  - Each cycle, scan cores round-robin starting at the dispatch pointer. Pick the first core with core_rdy=1 and no core_en pulse issued in the previous cycle.
  - If a core is picked and next_key < 2^KEY_BITS:
    - core_en[i]=1 and core_base=next_key[KEY_BITS-1:0].
    - next_key += CHUNK_SIZE.
    - Pointer moves to i+1, wrapping at NUM_CORES.
  - At most one dispatch per cycle.
- RUN, found:
  - Any core_found → latch key from the lowest-index asserting core, set key_valid=1, pulse core_abort next cycle, enter DONE.
  - Found has priority: no core_en is issued in the cycle a found is observed.
- RUN, exhausted:
  - When next_key >= 2^KEY_BITS, all core_rdy=1, no found, and no dispatch issued in the previous cycle → enter DONE with key_valid=0.
- DONE: rdy=1 next cycle, then return to IDLE. Later core_found pulses are ignored.
- ct arbiter:
  - Active in all states.
  - Grants one requester per cycle, round-robin from the arbitration pointer.
  - ct_addr = granted core's address, combinationally.
  - Next cycle: core_ct_rvalid[granted]=1 and core_ct_rdata=ct_rddata.
  - Arbitration pointer moves to granted+1.
  - No request → ct_addr holds its previous value and no grant is issued.
- Arithmetic:
  - Chunk i covers keys i*CHUNK_SIZE .. (i+1)*CHUNK_SIZE-1.
  - Total chunks = 2^KEY_BITS / CHUNK_SIZE.
  - next_key never wraps.

Optional Feature:
- CRACK_SCHED_STATS_EN defined:
  - Adds output chunks_done [15:0], the count of core_rdy rising edges during RUN. It saturates at 16'hFFFF and clears on en acceptance.
  - Adds output search_cycles [31:0], counting cycles in RUN.
- Undefined: both ports and their counters are absent.

Decomposition:
- Package crack_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Constants CT_ADDR_W=8, CT_DATA_W=8.
  - Function rr_pick(req, ptr), returning a one-hot result.
- Sub-module ct_rr_arbiter: the NUM_CORES-way round-robin arbiter with registered rvalid steering. Instantiated once.

Test Plan:
- NUM_CORES=2, KEY_BITS=8, CHUNK_SIZE=16, cores idle:
  - en → core_en[0] with base 0x00, then core_en[1] with base 0x10.
  - Each later core_rdy rise gets the next base (0x20, 0x30, …).
- Core 1 pulses core_found with key 0x47 while core 0 is busy → core_abort one cycle later, then rdy=1, key_valid=1, key=0x47.
- Both cores pulse found in the same cycle with keys 0x25 and 0x3A → key=0x25 (lowest index wins). Any later found pulse leaves key unchanged.
- No found, 16 chunks → exactly 16 core_en pulses with bases 0x00..0xF0, then rdy=1 and key_valid=0 after the last core_rdy rise.
- Both cores hold ct requests (addr 3 and 9) continuously → grants alternate 0,1,0,1, …. rvalid arrives one cycle after each grant, with rdata equal to mem[3] / mem[9].
- rst asserted mid-RUN → the next cycle shows every output at its reset value, and a subsequent en restarts dispatch at base 0x00.

Source files
------------

// File: rtl/crack_pkg.sv
// rtl/crack_pkg.sv - shared types, constants and round-robin pick helper for crack_sched
package crack_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CT_ADDR_W = 8;
    localparam int CT_DATA_W = 8;

    // One-hot pick of the first set bit of req at or after ptr, wrapping at n (n <= 8).
    // Scanning from the far end lets the closest candidate overwrite the others.
    function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [7:0] gnt;
        int         idx;
        gnt = '0;
        for (int k = 7; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (req[idx[2:0]]) begin
                    gnt = '0;
                    gnt[idx[2:0]] = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/crack_sched_if.sv
// rtl/crack_sched_if.sv - scheduler-to-cores bus: chunk dispatch, found/abort and ct read port
interface crack_sched_if #(
    parameter int NUM_CORES = 2,
    parameter int KEY_BITS  = 24
);
    logic [NUM_CORES-1:0]          core_en;
    logic [KEY_BITS-1:0]           core_base;
    logic [NUM_CORES-1:0]          core_rdy;
    logic [NUM_CORES-1:0]          core_found;
    logic [NUM_CORES*KEY_BITS-1:0] core_key;
    logic                          core_abort;
    logic [NUM_CORES-1:0]          core_ct_req;
    logic [NUM_CORES*8-1:0]        core_ct_addr;
    logic [NUM_CORES-1:0]          core_ct_gnt;
    logic [NUM_CORES-1:0]          core_ct_rvalid;
    logic [7:0]                    core_ct_rdata;

    modport master (
        output core_en, core_base, core_abort, core_ct_gnt, core_ct_rvalid, core_ct_rdata,
        input  core_rdy, core_found, core_key, core_ct_req, core_ct_addr
    );

    modport slave (
        input  core_en, core_base, core_abort, core_ct_gnt, core_ct_rvalid, core_ct_rdata,
        output core_rdy, core_found, core_key, core_ct_req, core_ct_addr
    );
endinterface

// File: rtl/ct_rr_arbiter.sv
// rtl/ct_rr_arbiter.sv - round-robin arbiter for the shared ct memory read port
module ct_rr_arbiter
    import crack_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*CT_ADDR_W-1:0] addr,
    input  logic [CT_DATA_W-1:0]   rddata,
    output logic [N-1:0]           gnt,
    output logic [N-1:0]           rvalid,
    output logic [CT_DATA_W-1:0]   rdata,
    output logic [CT_ADDR_W-1:0]   ct_addr
);
    localparam int PW = $clog2(N);

    logic [PW-1:0]        ptr, ptr_nx;
    logic [7:0]           pick8;
    logic [CT_ADDR_W-1:0] addr_sel, addr_q;

    always_comb begin
        pick8    = rr_pick(8'(req), 3'(ptr), N);
        gnt      = pick8[N-1:0];
        addr_sel = addr_q;
        ptr_nx   = ptr;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                addr_sel = addr[i*CT_ADDR_W +: CT_ADDR_W];
                ptr_nx   = (i == N-1) ? '0 : PW'(i + 1);
            end
        end
        ct_addr = addr_sel;
    end

    // Memory has one cycle of read latency, so its output lines up with the registered rvalid.
    assign rdata = rddata;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            rvalid <= '0;
            addr_q <= '0;
        end else begin
            rvalid <= gnt;
            if (|gnt) begin
                addr_q <= addr_sel;
                ptr    <= ptr_nx;
            end
        end
    end
endmodule

// File: rtl/crack_sched.sv
// rtl/crack_sched.sv - ARC4 key-search chunk scheduler; optional CRACK_SCHED_STATS_EN adds counters
module crack_sched
    import crack_pkg::*;
#(
    parameter int NUM_CORES  = 2,
    parameter int KEY_BITS   = 24,
    parameter int CHUNK_SIZE = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 rdy,
    output logic                 key_valid,
    output logic [KEY_BITS-1:0]  key,
    crack_sched_if.master        cif,
    output logic [CT_ADDR_W-1:0] ct_addr,
    input  logic [CT_DATA_W-1:0] ct_rddata
`ifdef CRACK_SCHED_STATS_EN
    ,
    output logic [15:0]          chunks_done,
    output logic [31:0]          search_cycles
`endif
);
    localparam int            PW        = $clog2(NUM_CORES);
    localparam logic [KEY_BITS:0] CHUNK_INC = (KEY_BITS+1)'(CHUNK_SIZE);

    state_t                 state, state_nx;
    logic [KEY_BITS:0]      next_key;
    logic [PW-1:0]          dptr, dptr_nx;
    logic [NUM_CORES-1:0]   en_q, pick;
    logic [7:0]             pick8;
    logic                   abort_q, any_found, keys_left, dispatch, start;
    logic [KEY_BITS-1:0]    found_key;

    always_comb begin
        pick8     = rr_pick(8'(cif.core_rdy & ~en_q), 3'(dptr), NUM_CORES);
        pick      = pick8[NUM_CORES-1:0];
        any_found = |cif.core_found;
        keys_left = !next_key[KEY_BITS];
        rdy       = (state != RUN);
        start     = rdy && en;
        dispatch  = (state == RUN) && !any_found && keys_left && (|pick);
        found_key = '0;
        for (int i = NUM_CORES-1; i >= 0; i--) begin
            if (cif.core_found[i]) found_key = cif.core_key[i*KEY_BITS +: KEY_BITS];
        end
        dptr_nx = dptr;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick[i]) dptr_nx = (i == NUM_CORES-1) ? '0 : PW'(i + 1);
        end
        cif.core_en    = dispatch ? pick : '0;
        cif.core_base  = next_key[KEY_BITS-1:0];
        cif.core_abort = abort_q;

        state_nx = state;
        case (state)
            IDLE: if (en) state_nx = RUN;
            RUN: begin
                if (any_found)
                    state_nx = DONE;
                else if (!keys_left && (&cif.core_rdy) && !(|en_q))
                    state_nx = DONE;
            end
            DONE: state_nx = en ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            next_key  <= '0;
            dptr      <= '0;
            en_q      <= '0;
            abort_q   <= 1'b0;
            key       <= '0;
            key_valid <= 1'b0;
        end else begin
            state   <= state_nx;
            en_q    <= cif.core_en;
            abort_q <= (state == RUN) && any_found;
            if (start) begin
                next_key  <= '0;
                key_valid <= 1'b0;
            end
            if (dispatch) begin
                next_key <= next_key + CHUNK_INC;
                dptr     <= dptr_nx;
            end
            if ((state == RUN) && any_found) begin
                key       <= found_key;
                key_valid <= 1'b1;
            end
        end
    end

    ct_rr_arbiter #(.N(NUM_CORES)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (cif.core_ct_req),
        .addr   (cif.core_ct_addr),
        .rddata (ct_rddata),
        .gnt    (cif.core_ct_gnt),
        .rvalid (cif.core_ct_rvalid),
        .rdata  (cif.core_ct_rdata),
        .ct_addr(ct_addr)
    );

`ifdef CRACK_SCHED_STATS_EN
    logic [NUM_CORES-1:0] rdy_q;
    logic [16:0]          chunks_sum;

    assign chunks_sum = {1'b0, chunks_done} + 17'($countones(cif.core_rdy & ~rdy_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q         <= '0;
            chunks_done   <= '0;
            search_cycles <= '0;
        end else begin
            rdy_q <= cif.core_rdy;
            if (start) begin
                chunks_done   <= '0;
                search_cycles <= '0;
            end else if (state == RUN) begin
                chunks_done   <= chunks_sum[16] ? 16'hFFFF : chunks_sum[15:0];
                search_cycles <= search_cycles + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_crack_sched.sv
// tb/tb_crack_sched.sv - directed self-checking bench for crack_sched (2 cores, 8-bit keys, 16-key chunks)
module tb_crack_sched;
    logic       clk = 1'b0;
    logic       rst, en;
    logic       rdy, key_valid;
    logic [7:0] key, ct_addr, ct_rddata;
    int         total = 0;
    int         bad = 0;
`ifdef CRACK_SCHED_STATS_EN
    logic [15:0] chunks_done;
    logic [31:0] search_cycles;
`endif

    crack_sched_if #(.NUM_CORES(2), .KEY_BITS(8)) cif ();

    crack_sched #(.NUM_CORES(2), .KEY_BITS(8), .CHUNK_SIZE(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rdy      (rdy),
        .key_valid(key_valid),
        .key      (key),
        .cif      (cif.master),
        .ct_addr  (ct_addr),
        .ct_rddata(ct_rddata)
`ifdef CRACK_SCHED_STATS_EN
        ,
        .chunks_done  (chunks_done),
        .search_cycles(search_cycles)
`endif
    );

    always #5 clk = ~clk;

    // ct memory image: mem[a] = a ^ 8'hA5, so mem[3]=8'hA6 and mem[9]=8'hAC
    always @(posedge clk) ct_rddata <= ct_addr ^ 8'hA5;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        cif.core_rdy = '0; cif.core_found = '0; cif.core_key = '0;
        cif.core_ct_req = '0; cif.core_ct_addr = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1; cif.core_rdy = 2'b11;
        @(negedge clk); #1;
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", rdy); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_key_valid got=%b want=0", key_valid); end
        total++; if (key !== 8'h00) begin bad++; $display("FAIL reset_key got=%h want=00", key); end
        total++; if (cif.core_en !== 2'b00) begin bad++; $display("FAIL reset_core_en got=%b want=00", cif.core_en); end
        total++; if (cif.core_base !== 8'h00) begin bad++; $display("FAIL reset_core_base got=%h want=00", cif.core_base); end
        total++; if (cif.core_abort !== 1'b0) begin bad++; $display("FAIL reset_abort got=%b want=0", cif.core_abort); end
        total++; if (cif.core_ct_rvalid !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b want=00", cif.core_ct_rvalid); end
        total++; if (ct_addr !== 8'h00) begin bad++; $display("FAIL reset_ct_addr got=%h want=00", ct_addr); end
        rst = 1'b0;
    endtask

    task automatic test_dispatch();
        do_reset();
        cif.core_rdy = 2'b11; en = 1'b1;
        @(negedge clk); en = 1'b0; #1;
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL disp_rdy_low got=%b want=0", rdy); end
        total++; if (cif.core_en !== 2'b01 || cif.core_base !== 8'h00) begin bad++; $display("FAIL disp_first got=%b/%h want=01/00", cif.core_en, cif.core_base); end
        @(negedge clk); cif.core_rdy = 2'b10; #1;
        total++; if (cif.core_en !== 2'b10 || cif.core_base !== 8'h10) begin bad++; $display("FAIL disp_second got=%b/%h want=10/10", cif.core_en, cif.core_base); end
        @(negedge clk); cif.core_rdy = 2'b00; #1;
        total++; if (cif.core_en !== 2'b00) begin bad++; $display("FAIL disp_busy got=%b want=00", cif.core_en); end
        @(negedge clk); cif.core_rdy = 2'b10; #1;
        total++; if (cif.core_en !== 2'b10 || cif.core_base !== 8'h20) begin bad++; $display("FAIL disp_third got=%b/%h want=10/20", cif.core_en, cif.core_base); end
        @(negedge clk); cif.core_rdy = 2'b00;
        @(negedge clk); cif.core_rdy = 2'b01; #1;
        total++; if (cif.core_en !== 2'b01 || cif.core_base !== 8'h30) begin bad++; $display("FAIL disp_fourth got=%b/%h want=01/30", cif.core_en, cif.core_base); end
    endtask

    task automatic test_found();
        do_reset();
        cif.core_rdy = 2'b11; en = 1'b1;
        @(negedge clk); en = 1'b0; cif.core_rdy = 2'b10;
        @(negedge clk); cif.core_rdy = 2'b00;
        @(negedge clk); cif.core_rdy = 2'b10; cif.core_found = 2'b10; cif.core_key = {8'h47, 8'h00}; #1;
        total++; if (cif.core_en !== 2'b00) begin bad++; $display("FAIL found_priority got=%b want=00", cif.core_en); end
        @(negedge clk); cif.core_found = 2'b00; cif.core_rdy = 2'b11; #1;
        total++; if (cif.core_abort !== 1'b1) begin bad++; $display("FAIL found_abort got=%b want=1", cif.core_abort); end
        total++; if (rdy !== 1'b1 || key_valid !== 1'b1) begin bad++; $display("FAIL found_flags got=%b%b want=11", rdy, key_valid); end
        total++; if (key !== 8'h47) begin bad++; $display("FAIL found_key got=%h want=47", key); end
        @(negedge clk); #1;
        total++; if (cif.core_abort !== 1'b0) begin bad++; $display("FAIL found_abort_pulse got=%b want=0", cif.core_abort); end
    endtask

    task automatic test_found_both();
        do_reset();
        cif.core_rdy = 2'b11; en = 1'b1;
        @(negedge clk); en = 1'b0;
        @(negedge clk); cif.core_rdy = 2'b10; cif.core_found = 2'b11; cif.core_key = {8'h3A, 8'h25}; #1;
        total++; if (cif.core_en !== 2'b00) begin bad++; $display("FAIL both_priority got=%b want=00", cif.core_en); end
        @(negedge clk); cif.core_found = 2'b10; cif.core_key = {8'h99, 8'h66}; #1;
        total++; if (key !== 8'h25 || key_valid !== 1'b1) begin bad++; $display("FAIL both_lowest got=%h/%b want=25/1", key, key_valid); end
        @(negedge clk); cif.core_found = 2'b01; cif.core_key = {8'h11, 8'h77};
        @(negedge clk); cif.core_found = 2'b00; #1;
        total++; if (key !== 8'h25) begin bad++; $display("FAIL both_late_ignored got=%h want=25", key); end
    endtask

    task automatic test_exhaust();
        logic [1:0] rdyv;
        int         busy [2];
        int         n_en;
        logic [7:0] exp_base;
        logic       done;
        do_reset();
        rdyv = 2'b11; busy[0] = 0; busy[1] = 0; n_en = 0; exp_base = 8'h00; done = 1'b0;
        cif.core_rdy = rdyv; en = 1'b1;
        @(negedge clk); en = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            cif.core_rdy = rdyv; #1;
            if (rdy) begin
                done = 1'b1;
            end else begin
                if (cif.core_en != 2'b00) begin
                    total++;
                    if (cif.core_base !== exp_base || $countones(cif.core_en) != 1)
                        begin bad++; $display("FAIL exh_base got=%b/%h want=onehot/%h", cif.core_en, cif.core_base, exp_base); end
                    exp_base = exp_base + 8'h10;
                    n_en++;
                end
                for (int i = 0; i < 2; i++) begin
                    if (cif.core_en[i]) begin
                        busy[i] = 2 + i; rdyv[i] = 1'b0;
                    end else if (busy[i] > 0) begin
                        busy[i]--;
                        if (busy[i] == 0) rdyv[i] = 1'b1;
                    end
                end
                @(negedge clk);
            end
        end
        total++; if (!done) begin bad++; $display("FAIL exh_timeout got=rdy0 want=rdy1"); end
        total++; if (n_en != 16) begin bad++; $display("FAIL exh_count got=%0d want=16", n_en); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL exh_key_valid got=%b want=0", key_valid); end
        total++; if (cif.core_rdy !== 2'b11) begin bad++; $display("FAIL exh_early_done got=%b want=11", cif.core_rdy); end
    endtask

    task automatic test_ct_arb();
        logic [1:0] exp_g, prev_g;
        do_reset();
        cif.core_ct_req = 2'b11; cif.core_ct_addr = {8'd9, 8'd3};
        prev_g = 2'b00;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
            total++; if (cif.core_ct_gnt !== exp_g) begin bad++; $display("FAIL arb_gnt%0d got=%b want=%b", k, cif.core_ct_gnt, exp_g); end
            total++; if (ct_addr !== (exp_g[1] ? 8'd9 : 8'd3)) begin bad++; $display("FAIL arb_addr%0d got=%h", k, ct_addr); end
            if (k > 0) begin
                total++; if (cif.core_ct_rvalid !== prev_g) begin bad++; $display("FAIL arb_rvalid%0d got=%b want=%b", k, cif.core_ct_rvalid, prev_g); end
                total++; if (cif.core_ct_rdata !== (prev_g[1] ? 8'hAC : 8'hA6)) begin bad++; $display("FAIL arb_rdata%0d got=%h", k, cif.core_ct_rdata); end
            end
            prev_g = exp_g;
            @(negedge clk);
        end
        cif.core_ct_req = 2'b00; #1;
        total++; if (cif.core_ct_gnt !== 2'b00) begin bad++; $display("FAIL arb_idle_gnt got=%b want=00", cif.core_ct_gnt); end
        total++; if (ct_addr !== 8'd9) begin bad++; $display("FAIL arb_hold_addr got=%h want=09", ct_addr); end
        total++; if (cif.core_ct_rvalid !== 2'b10 || cif.core_ct_rdata !== 8'hAC) begin bad++; $display("FAIL arb_last got=%b/%h want=10/ac", cif.core_ct_rvalid, cif.core_ct_rdata); end
        @(negedge clk); #1;
        total++; if (cif.core_ct_rvalid !== 2'b00) begin bad++; $display("FAIL arb_rvalid_clear got=%b want=00", cif.core_ct_rvalid); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        cif.core_rdy = 2'b11; en = 1'b1;
        @(negedge clk); en = 1'b0;
        @(negedge clk); cif.core_rdy = 2'b10; cif.core_ct_req = 2'b01; cif.core_ct_addr = {8'd0, 8'd5};
        @(negedge clk); rst = 1'b1; cif.core_rdy = 2'b11; cif.core_ct_req = 2'b00;
        @(negedge clk); #1;
        total++; if (rdy !== 1'b1 || cif.core_en !== 2'b00) begin bad++; $display("FAIL rst_mid_ctl got=%b/%b want=1/00", rdy, cif.core_en); end
        total++; if (cif.core_base !== 8'h00) begin bad++; $display("FAIL rst_mid_base got=%h want=00", cif.core_base); end
        total++; if (cif.core_abort !== 1'b0 || key_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_flags got=%b%b want=00", cif.core_abort, key_valid); end
        total++; if (cif.core_ct_rvalid !== 2'b00 || ct_addr !== 8'h00) begin bad++; $display("FAIL rst_mid_ct got=%b/%h want=00/00", cif.core_ct_rvalid, ct_addr); end
        rst = 1'b0; en = 1'b1;
        @(negedge clk); en = 1'b0; #1;
        total++; if (cif.core_en !== 2'b01 || cif.core_base !== 8'h00) begin bad++; $display("FAIL rst_mid_restart got=%b/%h want=01/00", cif.core_en, cif.core_base); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        cif.core_rdy = '0; cif.core_found = '0; cif.core_key = '0;
        cif.core_ct_req = '0; cif.core_ct_addr = '0;
        test_reset();
        test_dispatch();
        test_found();
        test_found_both();
        test_exhaust();
        test_ct_arb();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
